// File: rtl/jesd204_tx_link_pkg.sv
// Shared definitions for the JESD204 TX link-layer sequencer.
// Holds the state encoding, the ILAS config word count and the default SYNC~ debounce length.
package jesd204_tx_link_pkg;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } link_state_e;

    localparam int ILAS_CFG_WORDS        = 4;
    localparam int SYNC_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/jesd204_tx_link_sync.sv
// SYNC~ input conditioning: 2-FF synchroniser per link, link-disable masking
// and a down-counting debounce that flags sync loss while the link is in DATA.
module jesd204_tx_link_sync
    import jesd204_tx_link_pkg::*;
#(
    parameter int NUM_LINKS     = 1,
    parameter int SYNC_DEBOUNCE = SYNC_DEBOUNCE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_LINKS-1:0] sync,
    input  logic [NUM_LINKS-1:0] links_disable,
    input  logic                 debounce_en,
    output logic [NUM_LINKS-1:0] sync_status,
    output logic                 sync_ok,
    output logic                 sync_lost
);

    localparam logic [3:0] DBNC_LOAD = 4'(SYNC_DEBOUNCE);

    logic [NUM_LINKS-1:0] sync_meta;
    logic [NUM_LINKS-1:0] sync_q;
    logic [3:0]           dbnc_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= sync;
            sync_q    <= sync_meta;
        end
    end

    assign sync_ok = &(sync_q | links_disable);

    // Reloaded whenever sync is good or the link is not in DATA; terminal count is 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dbnc_cnt <= '0;
        end else if (!debounce_en || sync_ok) begin
            dbnc_cnt <= DBNC_LOAD;
        end else if (dbnc_cnt != 4'd1) begin
            dbnc_cnt <= dbnc_cnt - 4'd1;
        end
    end

    assign sync_lost   = debounce_en && !sync_ok && (dbnc_cnt == 4'd1);
    assign sync_status = sync_q;

endmodule

// File: rtl/jesd204_tx_link_ctrl.sv
// JESD204 TX link-layer sequencer: CGS -> ILAS -> DATA aligned to LMFC and SYNC~.
// Optional sync-loss counter enabled by JESD204_TX_LINK_CTRL_SYNC_LOSS_CNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_CGS  | send K28.5, wait for LMFC edge with all enabled SYNC~ high
// ST_ILAS | send ILAS multiframes, issue config reads in mframes 0/1
// ST_DATA | send user data, debounce SYNC~ loss back to CGS
module jesd204_tx_link_ctrl
    import jesd204_tx_link_pkg::*;
#(
    parameter int NUM_LINKS       = 1,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int SYNC_DEBOUNCE   = SYNC_DEBOUNCE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_skip_ilas,
    input  logic                 cfg_continuous_cgs,
    input  logic                 cfg_continuous_ilas,
    input  logic [7:0]           cfg_mframes_per_ilas,
    input  logic [7:0]           cfg_beats_per_mframe,
    input  logic [NUM_LINKS-1:0] cfg_links_disable,
    input  logic                 lmfc_edge,
    input  logic [NUM_LINKS-1:0] sync,
    input  logic                 manual_sync_request,
    output logic                 ilas_config_rd,
    output logic [1:0]           ilas_config_addr,
    output logic [1:0]           tx_sel,
    output logic [7:0]           tx_ilas_mframe,
    output logic [7:0]           tx_ilas_beat,
    output logic                 tx_data_ready,
    output logic [1:0]           status_state,
    output logic [NUM_LINKS-1:0] status_sync,
    output logic [7:0]           status_sync_loss_cnt
);

    // Beats needed to stream the 16 config octets through the lane mux.
    localparam int RD_BEATS = ILAS_CFG_WORDS * 4 / DATA_PATH_WIDTH;

    link_state_e state_q, state_nxt;
    logic [7:0]  beat_q, beat_nxt;
    logic [7:0]  mframe_q, mframe_nxt;
    logic [7:0]  beats_cfg_q, mframes_cfg_q;
    logic        sync_ok, sync_lost;
    logic        beat_last, mframe_last;
    logic [7:0]  beat_inc;

    jesd204_tx_link_sync #(
        .NUM_LINKS     (NUM_LINKS),
        .SYNC_DEBOUNCE (SYNC_DEBOUNCE)
    ) u_sync (
        .clk           (clk),
        .resetn        (resetn),
        .sync          (sync),
        .links_disable (cfg_links_disable),
        .debounce_en   (state_q == ST_DATA),
        .sync_status   (status_sync),
        .sync_ok       (sync_ok),
        .sync_lost     (sync_lost)
    );

    assign beat_inc    = beat_q + 8'd1;
    assign beat_last   = (beat_q == beats_cfg_q);
    assign mframe_last = (mframe_q == mframes_cfg_q);

    always_comb begin
        state_nxt  = state_q;
        beat_nxt   = '0;
        mframe_nxt = '0;
        case (state_q)
            ST_CGS: begin
                if (lmfc_edge && sync_ok && !cfg_continuous_cgs)
                    state_nxt = cfg_skip_ilas ? ST_DATA : ST_ILAS;
            end
            ST_ILAS: begin
                if (!sync_ok) begin
                    state_nxt = ST_CGS;
                end else begin
                    beat_nxt   = (lmfc_edge || beat_last) ? 8'd0 : beat_inc;
                    mframe_nxt = beat_last ? mframe_q + 8'd1 : mframe_q;
                    if (beat_last && mframe_last) begin
                        mframe_nxt = '0;
                        if (!cfg_continuous_ilas)
                            state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sync_lost)
                    state_nxt = ST_CGS;
            end
            default: state_nxt = ST_CGS;
        endcase
        if (manual_sync_request) begin
            state_nxt  = ST_CGS;
            beat_nxt   = '0;
            mframe_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_CGS;
            beat_q   <= '0;
            mframe_q <= '0;
        end else begin
            state_q  <= state_nxt;
            beat_q   <= beat_nxt;
            mframe_q <= mframe_nxt;
        end
    end

    // ILAS geometry is frozen for the whole ILAS sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beats_cfg_q   <= '0;
            mframes_cfg_q <= '0;
        end else if (state_q != ST_ILAS) begin
            beats_cfg_q   <= cfg_beats_per_mframe;
            mframes_cfg_q <= cfg_mframes_per_ilas;
        end
    end

    // Read is issued one beat ahead so data lands on beats 0..RD_BEATS-1 of mframe 1.
    always_comb begin
        ilas_config_rd   = 1'b0;
        ilas_config_addr = 2'd0;
        if (state_q == ST_ILAS) begin
            if (mframe_q == 8'd0 && beat_last) begin
                ilas_config_rd = 1'b1;
            end else if (mframe_q == 8'd1 && beat_q < 8'(RD_BEATS - 1)) begin
                ilas_config_rd   = 1'b1;
                ilas_config_addr = beat_inc[1:0];
            end
        end
    end

    assign tx_sel         = state_q;
    assign status_state   = state_q;
    assign tx_ilas_beat   = beat_q;
    assign tx_ilas_mframe = mframe_q;
    assign tx_data_ready  = (state_q == ST_DATA);

`ifdef JESD204_TX_LINK_CTRL_SYNC_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_cnt_q <= '0;
        end else if (state_q == ST_DATA && sync_lost && !manual_sync_request
                     && loss_cnt_q != 8'hff) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign status_sync_loss_cnt = loss_cnt_q;
`else
    assign status_sync_loss_cnt = 8'd0;
`endif

endmodule
